uart_tx_fifo: RTL and testbench

//  UART transmitter: the sending end of our 8-bit async serial link, the counterpart of the
//  led receive blocks, which sample o_txd directly. Bytes enter through a valid/ready handshake

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small byte FIFO feeding a UART serialiser.
// Frame: start (0), 8 data bits LSB first, optional parity, 1 or 2 stop bits (1).
// Every bit lasts exactly D clocks; o_txd comes straight from a flop.
module uart_tx_fifo #(
   parameter int unsigned D      = 5,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PARITY = 0,
   parameter int unsigned STOP   = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_txd,
   output logic       o_busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(D);
   localparam logic [BW-1:0] BcLast   = BW'(D - 1);
   localparam logic [CW-1:0] CntFull  = CW'(DEPTH);
   localparam logic          StopLast = (STOP == 2);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e          state;
   logic [BW-1:0]   bc;
   logic [2:0]      idx;
   logic [2:0]      idx_nxt;
   logic            stop_idx;
   logic [7:0]      shift;
   logic            txd;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            push;
   logic            pop;
   logic            bit_end;
   logic            stop_done;
   logic            par_bit;

   assign o_ready = (count != CntFull);
   assign o_busy  = (state != StIdle) || (count != '0);
   assign o_txd   = txd;

   // Handshake, pop and bit-timing decode from registered state.
   always_comb begin
      bit_end   = (bc == BcLast);
      stop_done = (state == StStop) && bit_end && (stop_idx == StopLast);
      // Pop only when a new frame can start: from idle, or right at the end of the last stop bit.
      pop       = (count != '0) && ((state == StIdle) || stop_done);
      push      = i_valid && o_ready;
      idx_nxt   = idx + 3'd1;
      par_bit   = (PARITY == 2) ? ~^shift : ^shift;
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep count unchanged.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Serialiser FSM; the line value is registered together with each state change.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= StIdle;
         bc       <= '0;
         idx      <= '0;
         stop_idx <= 1'b0;
         shift    <= '0;
         txd      <= 1'b1;
      end else begin
         // bc is always 0 in idle, since every bit ends with a wrap.
         if (state != StIdle) begin
            bc <= bit_end ? '0 : bc + BW'(1);
         end
         unique case (state)
            StIdle: begin
               if (pop) begin
                  shift <= mem[rd_ptr];
                  state <= StStart;
                  bc    <= '0;
                  txd   <= 1'b0;
               end
            end
            StStart: begin
               if (bit_end) begin
                  idx   <= '0;
                  state <= StData;
                  txd   <= shift[0];
               end
            end
            StData: begin
               if (bit_end) begin
                  if (idx == 3'd7) begin
                     if (PARITY != 0) begin
                        state <= StParity;
                        txd   <= par_bit;
                     end else begin
                        state    <= StStop;
                        stop_idx <= 1'b0;
                        txd      <= 1'b1;
                     end
                  end else begin
                     idx <= idx_nxt;
                     txd <= shift[idx_nxt];
                  end
               end
            end
            StParity: begin
               if (bit_end) begin
                  state    <= StStop;
                  stop_idx <= 1'b0;
                  txd      <= 1'b1;
               end
            end
            StStop: begin
               if (bit_end) begin
                  if (stop_idx != StopLast) begin
                     stop_idx <= 1'b1;
                  end else if (pop) begin
                     // Back-to-back frame: no idle gap.
                     shift <= mem[rd_ptr];
                     state <= StStart;
                     txd   <= 1'b0;
                  end else begin
                     state <= StIdle;
                     txd   <= 1'b1;
                  end
               end
            end
            default: begin
               state <= StIdle;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four parity/stop configurations driven concurrently, each
// checked every clock against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int D     = 5;
   localparam int DEPTH = 4;
   localparam int N     = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_s  [N];
   logic       valid_s [N];
   logic       ready_o [N];
   logic       txd_o   [N];
   logic       busy_o  [N];

   int n_checks;
   int n_pass;

   // Reference model state per instance.
   logic [7:0] mq      [N][DEPTH];
   int         mcnt    [N];
   bit         active  [N];
   int         pos     [N];
   logic [7:0] cur     [N];
   int         acc_cnt [N];

   // Instance g: 0 none/1 stop, 1 even/1 stop, 2 odd/1 stop, 3 none/2 stop.
   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_tx_fifo #(
         .D      (D),
         .DEPTH  (DEPTH),
         .PARITY ((g == 1) ? 1 : (g == 2) ? 2 : 0),
         .STOP   ((g == 3) ? 2 : 1)
      ) u_dut (
         .i_clk   (clk),
         .i_rst   (rst_n),
         .i_data  (data_s[g]),
         .i_valid (valid_s[g]),
         .o_ready (ready_o[g]),
         .o_txd   (txd_o[g]),
         .o_busy  (busy_o[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int par_of(input int n);
      return (n == 1) ? 1 : (n == 2) ? 2 : 0;
   endfunction

   function automatic int stop_of(input int n);
      return (n == 3) ? 2 : 1;
   endfunction

   function automatic int flen(input int n);
      return (10 + ((par_of(n) != 0) ? 1 : 0) + (stop_of(n) - 1)) * D;
   endfunction

   // Line level at clock p (0-based) of a frame carrying byte b.
   function automatic logic exp_bit(input int n, input logic [7:0] b, input int p);
      int k;
      k = p / D;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (par_of(n) != 0 && k == 9) return (par_of(n) == 1) ? ^b : ~^b;
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_clear();
      for (int n = 0; n < N; n++) begin
         mcnt[n]   = 0;
         active[n] = 1'b0;
         pos[n]    = 0;
         cur[n]    = 8'h00;
      end
   endtask

   // Model: a frame starts whenever the line is free (idle, or its last clock just shown)
   // and bytes are queued; accepts happen while fewer than DEPTH bytes wait.
   initial begin
      for (int n = 0; n < N; n++) acc_cnt[n] = 0;
      model_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_clear();
         end else begin
            for (int n = 0; n < N; n++) begin
               bit acc;
               bit done;
               acc  = valid_s[n] && (mcnt[n] != DEPTH);
               done = active[n] && (pos[n] == flen(n) - 1);
               if ((!active[n] || done) && mcnt[n] != 0) begin
                  cur[n] = mq[n][0];
                  for (int i = 0; i < DEPTH - 1; i++) mq[n][i] = mq[n][i+1];
                  mcnt[n]--;
                  active[n] = 1'b1;
                  pos[n]    = 0;
               end else if (done) begin
                  active[n] = 1'b0;
               end else if (active[n]) begin
                  pos[n]++;
               end
               if (acc) begin
                  mq[n][mcnt[n]] = data_s[n];
                  mcnt[n]++;
                  acc_cnt[n]++;
               end
            end
         end
      end
   end

   // Compare every output of every instance once per clock, away from the rising edge.
   always @(negedge clk) begin
      for (int n = 0; n < N; n++) begin
         check($sformatf("txd[%0d]", n), txd_o[n],
               active[n] ? exp_bit(n, cur[n], pos[n]) : 1'b1);
         check($sformatf("ready[%0d]", n), ready_o[n], mcnt[n] != DEPTH);
         check($sformatf("busy[%0d]", n), busy_o[n], active[n] || mcnt[n] != 0);
      end
   end

   // Present a byte and hold it until the model reports it accepted.
   task automatic send(input int n, input logic [7:0] b);
      int  start;
      bit  got;
      data_s[n]  = b;
      valid_s[n] = 1'b1;
      start      = acc_cnt[n];
      got        = 1'b0;
      for (int i = 0; i < 1000 && !got; i++) begin
         @(posedge clk);
         #1;
         got = (acc_cnt[n] != start);
      end
      check($sformatf("accept[%0d]", n), got, 1'b1);
      valid_s[n] = 1'b0;
   endtask

   task automatic wait_idle(input int n);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 3000 && !idle; i++) begin
         idle = !busy_o[n];
         if (!idle) begin
            @(posedge clk);
            #1;
         end
      end
      check($sformatf("idle[%0d]", n), idle, 1'b1);
   endtask

   task automatic run(input int n);
      int         k;
      logic [7:0] b;
      // Single byte; busy spans the accept clock plus the whole frame.
      send(n, 8'h55);
      k = 0;
      while (busy_o[n] && k < 1000) begin
         k++;
         @(posedge clk);
         #1;
      end
      check($sformatf("busy_len[%0d]", n), k, flen(n) + 1);
      send(n, 8'h07);
      wait_idle(n);
      send(n, 8'hA3);
      send(n, 8'h3C);
      wait_idle(n);
      // Overfill from idle: the last byte must be held until a slot frees.
      for (int i = 0; i < DEPTH + 2; i++) begin
         b = 8'h10 + 8'(i);
         send(n, b);
      end
      wait_idle(n);
      send(n, 8'h00);
      send(n, 8'hFF);
      send(n, 8'h81);
      wait_idle(n);
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         b = 8'($urandom_range(0, 255));
         send(n, b);
      end
      wait_idle(n);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      for (int n = 0; n < N; n++) begin
         valid_s[n] = 1'b0;
         data_s[n]  = 8'h00;
      end
      #32 rst_n = 1'b1;
      fork
         run(0);
         run(1);
         run(2);
         run(3);
      join
      // Abort frames in flight with an asynchronous reset.
      fork
         send(0, 8'hC5);
         send(1, 8'hC5);
         send(2, 8'hC5);
         send(3, 8'hC5);
      join
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int n = 0; n < N; n++) begin
         check($sformatf("rst_txd[%0d]", n), txd_o[n], 1'b1);
         check($sformatf("rst_busy[%0d]", n), busy_o[n], 1'b0);
         check($sformatf("rst_ready[%0d]", n), ready_o[n], 1'b1);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
